sprite_reg_writer: RTL and testbench
====================================

Name: sprite_reg_writer

Overview:
- Transmit side of the sprite register write interface: the port made of RAM_addr, wr_en and the write-data byte that the sprite datapath decodes.
- Snoops CPU writes to the sprite address window into a 33-entry shadow file during the frame.
- On each vblank_start pulse, replays the shadow onto the sprite write port. Sprite position, number, flip and palette then change only between frames, so sprites never tear mid-frame.
- Sits between the CPU bus and the sprite datapath, replacing the direct CPU-to-sprite write connection.

Parameters:
- REPLAY_ALL, 1: 1 = replay every entry each frame; 0 = replay only dirty entries.
- WR_GAP, 0: idle cycles inserted after each issued write (0..15).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- cpu_addr  in  16  CPU bus address
- cpu_din  in  8  CPU write data
- cpu_wr_en  in  1  CPU write strobe, one cycle per write
- vblank_start  in  1  one-cycle pulse at start of vertical blank
- spr_addr  out  16  sprite write address (to sprite datapath RAM_addr)
- spr_din  out  8  sprite write data (to sprite datapath data-in byte)
- spr_wr_en  out  1  sprite write strobe
- busy  out  1  replay in progress
- frame_done  out  1  one-cycle pulse when a replay completes
- overrun  out  1  sticky: vblank_start arrived while busy

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is asynchronous and active-high. While rst is high, all shadow bytes and dirty bits are 0, the FSM is in IDLE, and all outputs are 0.
- Shadow index map:
  - idx 0-15 ↔ addresses 0x4FF0-0x4FFF (number/flip at even addresses, palette at odd).
  - idx 16-31 ↔ 0x5060-0x506F (x at even addresses, y at odd).
  - idx 32 ↔ 0x5003 (flip-screen bit).
  - Any other address is ignored.
- Capture: on a clock edge with cpu_wr_en=1 and a mapped cpu_addr, shadow[idx] <= cpu_din and dirty[idx] <= 1. Capture is active in every FSM state and never stalls the CPU.
- FSM states: IDLE, SCAN, GAP.
  - IDLE: when vblank_start=1, go to SCAN with idx=0 and busy=1.
  - SCAN, entry needs a write (REPLAY_ALL=1, or dirty[idx]=1):
    - register spr_addr=map(idx), spr_din=shadow[idx] and spr_wr_en=1 on this edge;
    - clear dirty[idx];
    - if WR_GAP>0, go to GAP and load the gap counter with WR_GAP.
  - SCAN, entry does not need a write: spr_wr_en=0; advance idx; takes 1 cycle.
  - GAP: decrement the counter each cycle; at 0, advance idx and return to SCAN.
  - Leaving entry 32: go to IDLE, pulse frame_done for one cycle, busy=0.
- Outputs are registered. spr_wr_en is high for exactly one cycle per issued write, and spr_addr/spr_din are stable in that cycle. spr_addr/spr_din hold their last values when spr_wr_en=0.
- Timing with REPLAY_ALL=1, WR_GAP=0, vblank_start sampled at edge E0:
  - busy is high from after E0 until after E34;
  - entry k's write is visible in the cycle after edge E(k+1), so there are 33 consecutive write cycles;
  - frame_done is high in the cycle after E34, together with busy=0.
- Write order is strictly ascending idx. The flip-screen byte is always written last.
- CPU write to the entry being issued in the same cycle:
  - the pre-write shadow value is transmitted;
  - the shadow takes the new value;
  - dirty[idx] stays 1, so the value goes out in the next frame's replay.
- CPU write to an already-replayed entry during replay: its dirty bit is set and it is sent in the next frame.
- vblank_start while busy: ignored (no restart) and overrun <= 1. overrun clears only on rst.
- rst mid-replay: the replay is aborted immediately. No further spr_wr_en until the next vblank_start after rst deasserts.
- idx counter is 6 bits, range 0..32, and never wraps past 32.

Test Plan:
- Reset, then CPU writes 0x5060 <= 0x40 and 0x5061 <= 0x80. Then vblank_start with REPLAY_ALL=1, WR_GAP=0 → 33 consecutive spr_wr_en cycles:
  - write 16 is addr 0x5060 / data 0x40, write 17 is 0x5061 / 0x80;
  - all other data is 0x00;
  - last write is addr 0x5003;
  - frame_done pulses once.
- REPLAY_ALL=0; CPU writes 0x4FF4 <= 0x1E and 0x5003 <= 0x01; vblank_start → exactly 2 writes, (0x4FF4,0x1E) then (0x5003,0x01). A second vblank_start with no CPU writes → 0 writes and frame_done still pulses.
- WR_GAP=3, REPLAY_ALL=1 → consecutive spr_wr_en pulses are 4 cycles apart. busy lasts 33×4 cycles after E0.
- REPLAY_ALL=0: during replay, CPU writes 0x506E <= 0x22 in the same cycle idx 30 is issued (old shadow 0x11) → 0x11 is transmitted now and 0x22 on the next frame.
- vblank_start asserted mid-replay → no restart, overrun=1 and sticky, write count for that frame unchanged.
- rst pulsed at write 10 → spr_wr_en is 0 immediately, busy=0, shadow reads back 0 on the next REPLAY_ALL=1 replay.

Source files
------------

// File: rtl/sprite_reg_writer.sv
// Shadows CPU writes to the sprite register window during the frame and replays
// them onto the sprite write port at vblank, so sprite state changes only between frames.
module sprite_reg_writer #(
  parameter int REPLAY_ALL = 1,
  parameter int WR_GAP     = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  input  logic        cpu_wr_en,
  input  logic        vblank_start,
  output logic [15:0] spr_addr,
  output logic [7:0]  spr_din,
  output logic        spr_wr_en,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun
);

  typedef enum logic [1:0] {IDLE, SCAN, GAP} state_t;

  localparam logic [5:0] LastIdx = 6'd32;
  localparam logic [3:0] GapLoad = 4'(WR_GAP);

  state_t      r_state;
  logic [5:0]  r_idx;
  logic [3:0]  r_gap;
  logic [7:0]  r_shadow [0:32];
  logic [32:0] r_dirty;

  state_t      w_stateNext;
  logic [5:0]  w_idxNext;
  logic [3:0]  w_gapNext;
  logic        w_issue;
  logic        w_finish;
  logic        w_busyNext;
  logic        w_capValid;
  logic [5:0]  w_capIdx;
  logic        w_needWrite;

  function automatic logic [15:0] idxToAddr(input logic [5:0] idx);
    if (idx < 6'd16)
      return 16'h4FF0 + {12'd0, idx[3:0]};
    else if (idx < 6'd32)
      return 16'h5060 + {12'd0, idx[3:0]};
    else
      return 16'h5003;
  endfunction

  always_comb begin
    w_capValid = 1'b0;
    w_capIdx   = 6'd0;
    if (cpu_wr_en) begin
      if (cpu_addr[15:4] == 12'h4FF) begin
        w_capValid = 1'b1;
        w_capIdx   = {2'b00, cpu_addr[3:0]};
      end else if (cpu_addr[15:4] == 12'h506) begin
        w_capValid = 1'b1;
        w_capIdx   = {2'b01, cpu_addr[3:0]};
      end else if (cpu_addr == 16'h5003) begin
        w_capValid = 1'b1;
        w_capIdx   = LastIdx;
      end
    end
  end

  // A capture on the same edge as an issue wins over the dirty clear, so the new value goes out next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 33; i++) r_shadow[i] <= 8'h00;
      r_dirty <= '0;
    end else begin
      if (w_issue) r_dirty[r_idx] <= 1'b0;
      if (w_capValid) begin
        r_shadow[w_capIdx] <= cpu_din;
        r_dirty[w_capIdx]  <= 1'b1;
      end
    end
  end

  assign w_needWrite = (REPLAY_ALL != 0) || r_dirty[r_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= 6'd0;
      r_gap   <= 4'd0;
    end else begin
      r_state <= w_stateNext;
      r_idx   <= w_idxNext;
      r_gap   <= w_gapNext;
    end
  end

  // The last issued entry always passes through GAP, giving one closing cycle before frame_done.
  always_comb begin
    w_stateNext = r_state;
    w_idxNext   = r_idx;
    w_gapNext   = r_gap;
    w_issue     = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: begin
        if (vblank_start) begin
          w_stateNext = SCAN;
          w_idxNext   = 6'd0;
        end
      end
      SCAN: begin
        if (w_needWrite) begin
          w_issue = 1'b1;
          if ((WR_GAP > 0) || (r_idx == LastIdx)) begin
            w_stateNext = GAP;
            w_gapNext   = GapLoad;
          end else begin
            w_idxNext = r_idx + 6'd1;
          end
        end else if (r_idx == LastIdx) begin
          w_stateNext = IDLE;
          w_finish    = 1'b1;
        end else begin
          w_idxNext = r_idx + 6'd1;
        end
      end
      GAP: begin
        if (r_gap <= 4'd1) begin
          if (r_idx == LastIdx) begin
            w_stateNext = IDLE;
            w_finish    = 1'b1;
          end else begin
            w_stateNext = SCAN;
            w_idxNext   = r_idx + 6'd1;
          end
        end else begin
          w_gapNext = r_gap - 4'd1;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_comb begin
    w_busyNext = (w_stateNext != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spr_addr   <= 16'h0000;
      spr_din    <= 8'h00;
      spr_wr_en  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      spr_wr_en  <= w_issue;
      busy       <= w_busyNext;
      frame_done <= w_finish;
      if (vblank_start && (r_state != IDLE)) overrun <= 1'b1;
      if (w_issue) begin
        spr_addr <= idxToAddr(r_idx);
        spr_din  <= r_shadow[r_idx];
      end
    end
  end

endmodule

// File: tb/tb_sprite_reg_writer.sv
// Directed bench for sprite_reg_writer: three instances cover replay-all, dirty-only and
// gapped replay; all share the clock, reset and CPU/vblank stimulus.
module tb_sprite_reg_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cpuAddr = 16'h0000;
  logic [7:0]  cpuDin = 8'h00;
  logic        cpuWrEn = 1'b0;
  logic        vblank = 1'b0;

  logic [15:0] aAddr, bAddr, cAddr;
  logic [7:0]  aDin, bDin, cDin;
  logic        aWr, bWr, cWr, aBusy, bBusy, cBusy;
  logic        aDone, bDone, cDone, aOver, bOver, cOver;

  int checks = 0;
  int errors = 0;

  logic [15:0] recAddr [0:63];
  logic [7:0]  recDin [0:63];
  int          recCnt;
  int          recNonZero;
  bit          recDone;

  always #5 clk = ~clk;

  sprite_reg_writer #(.REPLAY_ALL(1), .WR_GAP(0)) dutA (
    .clk(clk), .rst(rst), .cpu_addr(cpuAddr), .cpu_din(cpuDin), .cpu_wr_en(cpuWrEn),
    .vblank_start(vblank), .spr_addr(aAddr), .spr_din(aDin), .spr_wr_en(aWr),
    .busy(aBusy), .frame_done(aDone), .overrun(aOver));

  sprite_reg_writer #(.REPLAY_ALL(0), .WR_GAP(0)) dutB (
    .clk(clk), .rst(rst), .cpu_addr(cpuAddr), .cpu_din(cpuDin), .cpu_wr_en(cpuWrEn),
    .vblank_start(vblank), .spr_addr(bAddr), .spr_din(bDin), .spr_wr_en(bWr),
    .busy(bBusy), .frame_done(bDone), .overrun(bOver));

  sprite_reg_writer #(.REPLAY_ALL(1), .WR_GAP(3)) dutC (
    .clk(clk), .rst(rst), .cpu_addr(cpuAddr), .cpu_din(cpuDin), .cpu_wr_en(cpuWrEn),
    .vblank_start(vblank), .spr_addr(cAddr), .spr_din(cDin), .spr_wr_en(cWr),
    .busy(cBusy), .frame_done(cDone), .overrun(cOver));

  function automatic logic [15:0] expAddr(input int k);
    if (k < 16) return 16'h4FF0 + 16'(k);
    else if (k < 32) return 16'h5060 + 16'(k - 16);
    else return 16'h5003;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset;
    rst = 1'b1;
    step;
    rst = 1'b0;
    step;
  endtask

  task automatic cpuWrite(input logic [15:0] addr, input logic [7:0] data);
    cpuAddr = addr;
    cpuDin  = data;
    cpuWrEn = 1'b1;
    step;
    cpuWrEn = 1'b0;
  endtask

  task automatic pulseVblank;
    vblank = 1'b1;
    step;
    vblank = 1'b0;
  endtask

  // Records writes of the selected instance (0=A, 1=B, 2=C) until frame_done or the cycle budget.
  task automatic collectFrame(input int sel, input int maxCycles);
    logic        wr, done;
    logic [15:0] addr;
    logic [7:0]  din;
    recCnt = 0;
    recNonZero = 0;
    recDone = 1'b0;
    for (int c = 0; c < maxCycles && !recDone; c++) begin
      step;
      if (sel == 0) begin wr = aWr; addr = aAddr; din = aDin; done = aDone; end
      else if (sel == 1) begin wr = bWr; addr = bAddr; din = bDin; done = bDone; end
      else begin wr = cWr; addr = cAddr; din = cDin; done = cDone; end
      if (wr === 1'b1) begin
        if (recCnt < 64) begin
          recAddr[recCnt] = addr;
          recDin[recCnt]  = din;
        end
        if (din !== 8'h00) recNonZero++;
        recCnt++;
      end
      if (done === 1'b1) recDone = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step;
    checks++;
    if (aWr !== 1'b0 || bWr !== 1'b0 || cWr !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_wr_en: got %b%b%b expected 000", aWr, bWr, cWr);
    end
    checks++;
    if ({aAddr, aDin} !== 24'h0) begin
      errors++; $display("[TB] FAIL reset_addr_data: got %h/%h expected 0000/00", aAddr, aDin);
    end
    checks++;
    if ({aBusy, aDone, aOver} !== 3'b000) begin
      errors++; $display("[TB] FAIL reset_status: got %b expected 000", {aBusy, aDone, aOver});
    end
    rst = 1'b0;
    step;
  endtask

  task automatic test_replay_all;
    logic [7:0] expD;
    doReset;
    cpuWrite(16'h5060, 8'h40);
    cpuWrite(16'h5061, 8'h80);
    pulseVblank;
    checks++;
    if (aBusy !== 1'b1 || aWr !== 1'b0) begin
      errors++; $display("[TB] FAIL busy_after_e0: got busy=%b wr=%b expected busy=1 wr=0", aBusy, aWr);
    end
    for (int k = 0; k < 33; k++) begin
      step;
      expD = (k == 16) ? 8'h40 : (k == 17) ? 8'h80 : 8'h00;
      checks++;
      if (aWr !== 1'b1 || aAddr !== expAddr(k) || aDin !== expD || aDone !== 1'b0) begin
        errors++;
        $display("[TB] FAIL replay_write_%0d: got wr=%b %h/%h done=%b expected wr=1 %h/%h done=0",
                 k, aWr, aAddr, aDin, aDone, expAddr(k), expD);
      end
    end
    step;
    checks++;
    if (aWr !== 1'b0 || aBusy !== 1'b0 || aDone !== 1'b1) begin
      errors++;
      $display("[TB] FAIL replay_end: got wr=%b busy=%b done=%b expected 0 0 1", aWr, aBusy, aDone);
    end
    step;
    checks++;
    if (aDone !== 1'b0 || aAddr !== 16'h5003) begin
      errors++; $display("[TB] FAIL done_one_cycle: got done=%b addr=%h expected 0 5003", aDone, aAddr);
    end
  endtask

  task automatic test_dirty_only;
    doReset;
    cpuWrite(16'h4FF4, 8'h1E);
    cpuWrite(16'h5003, 8'h01);
    pulseVblank;
    collectFrame(1, 60);
    checks++;
    if (recCnt !== 2 || !recDone) begin
      errors++; $display("[TB] FAIL dirty_count: got %0d writes done=%b expected 2 done=1", recCnt, recDone);
    end else begin
      checks++;
      if (recAddr[0] !== 16'h4FF4 || recDin[0] !== 8'h1E) begin
        errors++; $display("[TB] FAIL dirty_first: got %h/%h expected 4ff4/1e", recAddr[0], recDin[0]);
      end
      checks++;
      if (recAddr[1] !== 16'h5003 || recDin[1] !== 8'h01) begin
        errors++; $display("[TB] FAIL dirty_second: got %h/%h expected 5003/01", recAddr[1], recDin[1]);
      end
    end
    pulseVblank;
    collectFrame(1, 60);
    checks++;
    if (recCnt !== 0 || !recDone) begin
      errors++; $display("[TB] FAIL dirty_empty_frame: got %0d writes done=%b expected 0 done=1", recCnt, recDone);
    end
  endtask

  task automatic test_gap;
    int lastN, nWr, badGap, busyCnt;
    bit done;
    doReset;
    pulseVblank;
    lastN = -1; nWr = 0; badGap = 0; busyCnt = 0; done = 1'b0;
    if (cBusy === 1'b1) busyCnt++;
    for (int n = 1; n <= 200 && !done; n++) begin
      step;
      if (cWr === 1'b1) begin
        if ((lastN < 0 && n != 1) || (lastN >= 0 && n - lastN != 4)) badGap++;
        lastN = n;
        nWr++;
      end
      if (cBusy === 1'b1) busyCnt++;
      if (cDone === 1'b1) begin
        done = 1'b1;
        checks++;
        if (n != 132) begin
          errors++; $display("[TB] FAIL gap_done_cycle: got %0d expected 132", n);
        end
      end
    end
    checks++;
    if (nWr != 33 || badGap != 0) begin
      errors++; $display("[TB] FAIL gap_spacing: got %0d writes %0d bad gaps expected 33 0", nWr, badGap);
    end
    checks++;
    if (busyCnt != 132 || !done) begin
      errors++; $display("[TB] FAIL gap_busy_len: got %0d done=%b expected 132 done=1", busyCnt, done);
    end
  endtask

  task automatic test_same_cycle;
    doReset;
    cpuWrite(16'h506E, 8'h11);
    pulseVblank;
    repeat (30) step;
    cpuAddr = 16'h506E;
    cpuDin  = 8'h22;
    cpuWrEn = 1'b1;
    step;
    cpuWrEn = 1'b0;
    checks++;
    if (bWr !== 1'b1 || bAddr !== 16'h506E || bDin !== 8'h11) begin
      errors++; $display("[TB] FAIL same_cycle_old: got wr=%b %h/%h expected wr=1 506e/11", bWr, bAddr, bDin);
    end
    collectFrame(1, 20);
    checks++;
    if (recCnt !== 0 || !recDone) begin
      errors++; $display("[TB] FAIL same_cycle_tail: got %0d writes done=%b expected 0 done=1", recCnt, recDone);
    end
    pulseVblank;
    collectFrame(1, 60);
    checks++;
    if (recCnt !== 1 || recAddr[0] !== 16'h506E || recDin[0] !== 8'h22) begin
      errors++; $display("[TB] FAIL same_cycle_next: got %0d writes %h/%h expected 1 506e/22", recCnt, recAddr[0], recDin[0]);
    end
  endtask

  task automatic test_overrun;
    int pre, stray;
    doReset;
    pulseVblank;
    pre = 0;
    repeat (9) begin
      step;
      if (aWr === 1'b1) pre++;
    end
    vblank = 1'b1;
    step;
    vblank = 1'b0;
    if (aWr === 1'b1) pre++;
    checks++;
    if (aOver !== 1'b1 || aBusy !== 1'b1) begin
      errors++; $display("[TB] FAIL overrun_set: got over=%b busy=%b expected 1 1", aOver, aBusy);
    end
    collectFrame(0, 60);
    checks++;
    if (pre + recCnt != 33 || !recDone) begin
      errors++; $display("[TB] FAIL overrun_count: got %0d writes done=%b expected 33 done=1", pre + recCnt, recDone);
    end
    stray = 0;
    repeat (5) begin
      step;
      if (aWr === 1'b1 || aBusy === 1'b1) stray++;
    end
    checks++;
    if (stray != 0 || aOver !== 1'b1) begin
      errors++; $display("[TB] FAIL overrun_sticky: got stray=%0d over=%b expected 0 1", stray, aOver);
    end
  endtask

  task automatic test_reset_mid;
    int n, stray;
    doReset;
    cpuWrite(16'h4FF0, 8'hAA);
    cpuWrite(16'h5003, 8'h55);
    cpuWrite(16'h506F, 8'h33);
    pulseVblank;
    n = 0;
    for (int c = 0; c < 40 && n < 10; c++) begin
      step;
      if (aWr === 1'b1) n++;
    end
    rst = 1'b1;
    #1;
    checks++;
    if (n != 10 || aWr !== 1'b0 || aBusy !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_abort: got n=%0d wr=%b busy=%b expected 10 0 0", n, aWr, aBusy);
    end
    step;
    rst = 1'b0;
    stray = 0;
    repeat (5) begin
      step;
      if (aWr === 1'b1 || aBusy === 1'b1) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++; $display("[TB] FAIL reset_quiet: got %0d active cycles expected 0", stray);
    end
    pulseVblank;
    collectFrame(0, 60);
    checks++;
    if (recCnt != 33 || recNonZero != 0 || !recDone) begin
      errors++;
      $display("[TB] FAIL reset_shadow_clear: got %0d writes %0d nonzero done=%b expected 33 0 1",
               recCnt, recNonZero, recDone);
    end
  endtask

  initial begin
    $display("[TB] sprite_reg_writer bench start");
    test_reset;
    test_replay_all;
    test_dirty_only;
    test_gap;
    test_same_cycle;
    test_overrun;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
